// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered N-channel valid/ready multiplexer.
// Selects one producer per cycle, either the fixed channel S or by
// round-robin arbitration, and holds the word plus its source channel
// in a single output register that supports full-throughput replace.
module mux_rr_reg #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MODE,
  input  logic [SW-1:0]   S,
  input  logic [N*W-1:0]  D,
  input  logic [N-1:0]    D_VALID,
  output logic [N-1:0]    D_READY,
  output logic [W-1:0]    Y,
  output logic [SW-1:0]   Y_CH,
  output logic            Y_VALID,
  input  logic            Y_READY
);

  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   rr_sum;
  logic [W-1:0]  sel_data;
  logic          load_ok;
  logic          xfer_in;
  logic          xfer_out;

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ych_q, ych_d;
  logic          yv_q, yv_d;
  logic [SW-1:0] ptr_q, ptr_d;

  // Grant selection: fixed channel S, or first valid channel after PTR.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    if (!MODE) begin
      // An S beyond N-1 matches no channel, so it yields no grant.
      for (int unsigned i = 0; i < N; i++) begin
        if (S == SW'(i) && D_VALID[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      // Scan PTR+1 .. PTR+N with wrap; the one-bit-wider sum avoids overflow.
      for (int unsigned k = 1; k <= N; k++) begin
        rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
        if (rr_sum >= (SW+1)'(N)) begin
          rr_sum = rr_sum - (SW+1)'(N);
        end
        if (!grant_vld && D_VALID[rr_sum[SW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = rr_sum[SW-1:0];
        end
      end
    end
  end

  // Handshake qualification and data selection for the granted channel.
  always_comb begin
    load_ok  = !yv_q || Y_READY;
    xfer_in  = grant_vld && load_ok;
    xfer_out = yv_q && Y_READY;
    D_READY  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      D_READY[i] = grant_vld && load_ok && (grant_idx == SW'(i));
      if (grant_idx == SW'(i)) begin
        sel_data = D[i*W +: W];
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    y_d   = y_q;
    ych_d = ych_q;
    yv_d  = yv_q;
    ptr_d = ptr_q;
    if (xfer_in) begin
      y_d   = sel_data;
      ych_d = grant_idx;
      yv_d  = 1'b1;
      if (MODE) begin
        ptr_d = grant_idx;
      end
    end else if (xfer_out) begin
      yv_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      ych_q <= '0;
      yv_q  <= 1'b0;
      ptr_q <= SW'(N-1);
    end else begin
      y_q   <= y_d;
      ych_q <= ych_d;
      yv_q  <= yv_d;
      ptr_q <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign Y_CH    = ych_q;
  assign Y_VALID = yv_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: scenario tasks for mux_rr_reg with a scoreboard of
// expected {channel, data} words and a small reference arbitration model.
module tb_mux_rr_reg;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   s;
  logic [N*W-1:0]  d;
  logic [N-1:0]    dv;
  logic [N-1:0]    drdy;
  logic [W-1:0]    y;
  logic [SW-1:0]   ych;
  logic            yv;
  logic            yr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int                   m_ptr;
  logic                 m_yv;
  logic [SW+W-1:0]      sb[$];

  mux_rr_reg #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .MODE    (mode),
    .S       (s),
    .D       (d),
    .D_VALID (dv),
    .D_READY (drdy),
    .Y       (y),
    .Y_CH    (ych),
    .Y_VALID (yv),
    .Y_READY (yr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    if (!mode) begin
      if (int'(s) < N && dv[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (dv[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0 && (!m_yv || yr)) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    int   g;
    logic xin, xout;
    g    = model_grant();
    xin  = (g >= 0) && (!m_yv || yr);
    xout = m_yv && yr;
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      m_yv  = 1'b0;
      m_ptr = N - 1;
    end else begin
      if (xout) void'(sb.pop_front());
      if (xin) begin
        sb.push_back({SW'(g), d[g*W +: W]});
        if (mode) m_ptr = g;
      end
      m_yv = xin ? 1'b1 : (xout ? 1'b0 : m_yv);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [SW+W-1:0] e;
    rst_n = 1'b0; mode = 1'b1; s = '0; yr = 1'b1; dv = '1;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'h10 + i);
    tick();
    tick();
    checks++;
    if (yv !== 1'b0) begin failures++; $display("FAIL reset_yvalid got=%b exp=0", yv); end
    checks++;
    if (y !== '0) begin failures++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++;
    if (ych !== '0) begin failures++; $display("FAIL reset_ych got=%0d exp=0", ych); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (drdy !== 4'b0001) begin failures++; $display("FAIL reset_first_ready got=%b exp=0001", drdy); end
    tick();
    e = sb[0];
    checks++;
    if (yv !== 1'b1 || ych !== 2'd0 || y !== e[W-1:0]) begin
      failures++; $display("FAIL reset_first_grant got v=%b ch=%0d y=%h exp v=1 ch=0 y=%h", yv, ych, y, e[W-1:0]);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; s = 2'd2; dv = 4'b1111; yr = 1'b1;
    d[2*W +: W] = 8'hA5;
    #1;
    checks++;
    if (drdy !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b exp=0100", drdy); end
    tick();
    checks++;
    if (y !== 8'hA5 || ych !== 2'd2 || yv !== 1'b1) begin
      failures++; $display("FAIL fixed_word got y=%h ch=%0d v=%b exp y=a5 ch=2 v=1", y, ych, yv);
    end
    dv[2] = 1'b0;
    #1;
    checks++;
    if (drdy !== 4'b0000) begin failures++; $display("FAIL fixed_noready got=%b exp=0000", drdy); end
    tick();
    checks++;
    if (yv !== 1'b0 || yv !== m_yv) begin failures++; $display("FAIL fixed_drain got=%b exp=0", yv); end
    checks++;
    if (y !== 8'hA5) begin failures++; $display("FAIL fixed_hold got=%h exp=a5", y); end
  endtask

  task automatic test_rr_wrap();
    logic [SW+W-1:0] e;
    int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    mode = 1'b1; dv = 4'b1111; yr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      #1;
      checks++;
      if (drdy !== model_ready() || drdy !== (4'b0001 << exp_ch[k])) begin
        failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, drdy, 4'b0001 << exp_ch[k]);
      end
      tick();
      e = sb[0];
      checks++;
      if (yv !== 1'b1 || ych !== SW'(exp_ch[k]) || y !== e[W-1:0] || ych !== e[SW+W-1:W]) begin
        failures++; $display("FAIL rr_word[%0d] got v=%b ch=%0d y=%h exp v=1 ch=%0d y=%h", k, yv, ych, y, exp_ch[k], e[W-1:0]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [SW+W-1:0] e;
    int exp_ch[5] = '{2, 3, 1, 3, 1};
    mode = 1'b1; dv = 4'b1111; yr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) dv = 4'b1010;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      tick();
      e = sb[0];
      checks++;
      if (yv !== 1'b1 || ych !== SW'(exp_ch[k]) || y !== e[W-1:0]) begin
        failures++; $display("FAIL sparse_word[%0d] got ch=%0d y=%h exp ch=%0d y=%h", k, ych, y, exp_ch[k], e[W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SW+W-1:0] held;
    logic [SW+W-1:0] e;
    held = sb[0];
    yr = 1'b0; dv = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom} & {(N*W){1'b1}};
      #1;
      checks++;
      if (drdy !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, drdy); end
      tick();
      checks++;
      if (yv !== 1'b1 || y !== held[W-1:0] || ych !== held[SW+W-1:W]) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d y=%h exp v=1 ch=%0d y=%h", k, yv, ych, y, held[SW+W-1:W], held[W-1:0]);
      end
    end
    yr = 1'b1;
    #1;
    checks++;
    if (drdy !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", drdy); end
    tick();
    e = sb[0];
    checks++;
    if (yv !== 1'b1 || ych !== 2'd2 || y !== e[W-1:0] || sb.size() != 1) begin
      failures++; $display("FAIL bp_replace got v=%b ch=%0d y=%h exp v=1 ch=2 y=%h", yv, ych, y, e[W-1:0]);
    end
  endtask

  task automatic test_mode_switch();
    logic [SW+W-1:0] e;
    int exp_ch[4] = '{1, 3, 3, 2};
    yr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin mode = 1'b1; dv = 4'b0010; end
        1, 2:    begin mode = 1'b0; s = 2'd3; dv = 4'b1111; end
        default: begin mode = 1'b1; dv = 4'b1111; end
      endcase
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      tick();
      e = sb[0];
      checks++;
      if (yv !== 1'b1 || ych !== SW'(exp_ch[k]) || y !== e[W-1:0]) begin
        failures++; $display("FAIL mode_word[%0d] got ch=%0d y=%h exp ch=%0d y=%h", k, ych, y, exp_ch[k], e[W-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    yr = 1'b0; dv = 4'b1111; mode = 1'b1;
    checks++;
    if (yv !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", yv); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (yv !== 1'b0 || y !== '0 || ych !== '0) begin
      failures++; $display("FAIL midrst_drop got v=%b y=%h ch=%0d exp v=0 y=00 ch=0", yv, y, ych);
    end
    rst_n = 1'b1; yr = 1'b1;
    tick();
    checks++;
    if (ych !== 2'd0 || yv !== 1'b1) begin failures++; $display("FAIL midrst_first got ch=%0d v=%b exp ch=0 v=1", ych, yv); end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; s = '0; d = '0; dv = '0; yr = 1'b0;
    m_ptr = N - 1; m_yv = 1'b0;
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_rr_sparse();
    test_backpressure();
    test_mode_switch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
